// File: rtl/fifo_level_pkg.sv
// Shared width helpers for the fill-level FIFO and its pointer sub-module.
// All widths are elaboration-time constants derived from DEPTH/OUT_REG.
package fifo_level_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Storage address width; a 2-entry FIFO still needs one address bit.
  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  // Fill level can reach DEPTH, plus one when the output register is present.
  function automatic int count_width(input int depth, input int out_reg);
    return clog2(depth + out_reg + 1);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with a wrap bit that toggles on every roll-over,
// so equal addresses can be told apart as full or empty.
module fifo_wrap_ptr
  import fifo_level_pkg::*;
#(
  parameter int DEPTH = 6,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic          wrap
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= '0;
      wrap <= 1'b0;
    end else if (clear) begin
      addr <= '0;
      wrap <= 1'b0;
    end else if (advance) begin
      if (addr == LAST) begin
        addr <= '0;
        wrap <= ~wrap;
      end else begin
        addr <= addr + AW'(1);
      end
    end
  end

endmodule

// File: rtl/fifo_level.sv
// Valid/ready FIFO with registered fill level and almost-full/empty flags;
// optional registered output stage adds one word of capacity.
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 6,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  parameter int OUT_REG   = 0,
  localparam int CW       = count_width(DEPTH, OUT_REG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DWIDTH-1:0] o_data,
  output logic [CW-1:0]     o_count,
  output logic              o_afull,
  output logic              o_aempty
);

  localparam int AW = ptr_width(DEPTH);

  logic [AW-1:0]     waddr;
  logic [AW-1:0]     raddr;
  logic              wwrap;
  logic              rwrap;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              rd_adv;
  logic [CW-1:0]     count;
  logic [DWIDTH-1:0] mem [DEPTH];

  assign full    = (waddr == raddr) && (wwrap != rwrap);
  assign empty   = (waddr == raddr) && (wwrap == rwrap);
  assign o_ready = !full;
  // Acceptance looks only at storage fullness, so a same-cycle pop never frees room.
  assign push    = i_valid && !full;

  fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_flush),
    .advance (push),
    .addr    (waddr),
    .wrap    (wwrap)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
    .clk     (clk),
    .reset   (reset),
    .clear   (i_flush),
    .advance (rd_adv),
    .addr    (raddr),
    .wrap    (rwrap)
  );

  // NOTE: the storage array has no reset so it maps onto distributed RAM;
  // its contents are only observable behind a valid pointer range.
  always_ff @(posedge clk) begin
    if (push && !i_flush) begin
      mem[waddr] <= i_data;
    end
  end

  if (OUT_REG == 0) begin : g_show_ahead
    assign pop     = !empty && i_ready;
    assign rd_adv  = pop;
    assign o_valid = !empty;
    assign o_data  = mem[raddr];
  end else begin : g_out_reg
    logic              out_valid;
    logic [DWIDTH-1:0] out_data;

    // Refill whenever the register is free or being drained this cycle.
    assign pop    = out_valid && i_ready;
    assign rd_adv = !empty && (!out_valid || i_ready);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_valid <= 1'b0;
      end else if (i_flush) begin
        out_valid <= 1'b0;
      end else if (rd_adv) begin
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rd_adv && !i_flush) begin
        out_data <= mem[raddr];
      end
    end

    assign o_valid = out_valid;
    assign o_data  = out_data;
  end

  // Level tracks external push/pop only; internal refills move words, not count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (i_flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  assign o_count  = count;
  assign o_afull  = (count >= CW'(AFULL_TH));
  assign o_aempty = (count <= CW'(AEMPTY_TH));

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench for fifo_level: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_fifo_level;

  localparam int DW    = 8;
  localparam int DEPTH = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Show-ahead instance
  logic       flush0, valid0, ready0;
  logic [7:0] data0;
  logic       o_ready0, o_valid0, afull0, aempty0;
  logic [7:0] odata0;
  logic [2:0] count0;

  // Registered-output instance
  logic       flush1, valid1, ready1;
  logic [7:0] data1;
  logic       o_ready1, o_valid1, afull1, aempty1;
  logic [7:0] odata1;
  logic [2:0] count1;

  fifo_level #(.DWIDTH(DW), .DEPTH(DEPTH), .OUT_REG(0)) dut0 (
    .clk(clk), .reset(reset), .i_flush(flush0), .i_valid(valid0), .o_ready(o_ready0),
    .i_data(data0), .o_valid(o_valid0), .i_ready(ready0), .o_data(odata0),
    .o_count(count0), .o_afull(afull0), .o_aempty(aempty0)
  );

  fifo_level #(.DWIDTH(DW), .DEPTH(DEPTH), .OUT_REG(1)) dut1 (
    .clk(clk), .reset(reset), .i_flush(flush1), .i_valid(valid1), .o_ready(o_ready1),
    .i_data(data1), .o_valid(o_valid1), .i_ready(ready1), .o_data(odata1),
    .o_count(count1), .o_afull(afull1), .o_aempty(aempty1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents of the show-ahead FIFO, head at index 0.
  logic [7:0] q[$];

  typedef struct {
    logic       flush;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_data;
    int         e_count;
    logic       e_afull;
    logic       e_aempty;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic f, input logic v, input logic [7:0] d, input logic r,
                              input logic er, input logic ev, input logic [7:0] ed,
                              input int ec, input logic eaf, input logic eae);
    vec_t t;
    t.flush = f;  t.valid = v;  t.data = d;  t.ready = r;
    t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_count = ec;
    t.e_afull = eaf; t.e_aempty = eae;
    return t;
  endfunction

  // Drive one cycle on dut0 (starting at a negedge), advance to the next negedge
  // and update the model using the pre-edge occupancy.
  task automatic step0(input logic f, input logic v, input logic [7:0] d, input logic r);
    bit do_push;
    bit do_pop;
    flush0 = f; valid0 = v; data0 = d; ready0 = r;
    do_push = v && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
    @(negedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    check($sformatf("%s count", tag), 32'(count0), 32'(q.size()));
    check($sformatf("%s o_ready", tag), 32'(o_ready0), 32'(q.size() < DEPTH));
    check($sformatf("%s o_valid", tag), 32'(o_valid0), 32'(q.size() > 0));
    check($sformatf("%s o_afull", tag), 32'(afull0), 32'(q.size() >= DEPTH - 1));
    check($sformatf("%s o_aempty", tag), 32'(aempty0), 32'(q.size() <= 1));
    if (q.size() > 0) check($sformatf("%s o_data", tag), 32'(odata0), 32'(q[0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    int got;
    reset = 1'b1;
    flush0 = 0; valid0 = 0; ready0 = 0; data0 = '0;
    flush1 = 0; valid1 = 0; ready1 = 0; data1 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("reset o_valid", 32'(o_valid0), 0);
    check("reset o_ready", 32'(o_ready0), 1);
    check("reset o_count", 32'(count0), 0);
    check("reset o_afull", 32'(afull0), 0);
    check("reset o_aempty", 32'(aempty0), 1);
    check("reset oreg o_valid", 32'(o_valid1), 0);
    check("reset oreg o_count", 32'(count1), 0);

    // Fill to full, pop-while-full rejects push, refill, drain, pop on empty.
    vecs.push_back(mk(0, 1, 8'h01, 0,  1, 1, 8'h01, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'h02, 0,  1, 1, 8'h01, 2, 0, 0));
    vecs.push_back(mk(0, 1, 8'h03, 0,  1, 1, 8'h01, 3, 0, 0));
    vecs.push_back(mk(0, 1, 8'h04, 0,  1, 1, 8'h01, 4, 0, 0));
    vecs.push_back(mk(0, 1, 8'h05, 0,  1, 1, 8'h01, 5, 1, 0));
    vecs.push_back(mk(0, 1, 8'h06, 0,  0, 1, 8'h01, 6, 1, 0));
    vecs.push_back(mk(0, 1, 8'h07, 1,  1, 1, 8'h02, 5, 1, 0));
    vecs.push_back(mk(0, 1, 8'h07, 0,  0, 1, 8'h02, 6, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h03, 5, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h04, 4, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h05, 3, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h06, 2, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 1, 8'h07, 1, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 0, 0, 1));

    foreach (vecs[i]) begin
      step0(vecs[i].flush, vecs[i].valid, vecs[i].data, vecs[i].ready);
      check($sformatf("vec%0d o_ready", i), 32'(o_ready0), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d o_valid", i), 32'(o_valid0), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d o_count", i), 32'(count0), 32'(vecs[i].e_count));
      check($sformatf("vec%0d o_afull", i), 32'(afull0), 32'(vecs[i].e_afull));
      check($sformatf("vec%0d o_aempty", i), 32'(aempty0), 32'(vecs[i].e_aempty));
      if (vecs[i].e_valid) check($sformatf("vec%0d o_data", i), 32'(odata0), 32'(vecs[i].e_data));
    end

    // Streaming push+pop at constant level across several pointer wraps.
    for (int i = 0; i < 3; i++) step0(0, 1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 20; i++) begin
      check("stream o_data", 32'(odata0), 32'(8'h40 + i));
      step0(0, 1, 8'(8'h43 + i), 1);
      check("stream o_count", 32'(count0), 3);
    end
    for (int i = 0; i < 3; i++) begin
      check("stream tail", 32'(odata0), 32'(8'h54 + i));
      step0(0, 0, 8'h00, 1);
    end
    check_model("stream drained");

    // Flush at level 4 with a simultaneous push.
    for (int i = 0; i < 4; i++) step0(0, 1, 8'(8'h80 + i), 0);
    check("preflush o_count", 32'(count0), 4);
    step0(1, 1, 8'h99, 0);
    check("flush o_count", 32'(count0), 0);
    check("flush o_valid", 32'(o_valid0), 0);
    step0(0, 1, 8'h55, 0);
    check("postflush o_data", 32'(odata0), 32'h55);
    check("postflush o_count", 32'(count0), 1);
    step0(0, 0, 8'h00, 1);
    check_model("postflush drained");

    // Asynchronous reset between edges at level 3.
    for (int i = 0; i < 3; i++) step0(0, 1, 8'(8'hC0 + i), 0);
    valid0 = 0;
    check("prereset o_count", 32'(count0), 3);
    #2 reset = 1'b1;
    #1;
    check("async reset o_valid", 32'(o_valid0), 0);
    check("async reset o_count", 32'(count0), 0);
    check("async reset o_ready", 32'(o_ready0), 1);
    check("async reset o_aempty", 32'(aempty0), 1);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    step0(0, 1, 8'h33, 0);
    step0(0, 1, 8'h34, 0);
    check("post reset first word", 32'(odata0), 32'h33);
    step0(0, 0, 8'h00, 1);
    check("post reset second word", 32'(odata0), 32'h34);
    step0(0, 0, 8'h00, 1);
    check_model("post reset drained");

    // Registered output: two-cycle latency, capacity DEPTH+1, order on drain.
    valid1 = 1; data1 = 8'hA5; ready1 = 1;
    @(negedge clk);
    valid1 = 0;
    check("oreg latency N o_valid", 32'(o_valid1), 0);
    @(negedge clk);
    check("oreg latency N+1 o_valid", 32'(o_valid1), 1);
    check("oreg latency o_data", 32'(odata1), 32'hA5);
    check("oreg latency o_count", 32'(count1), 1);
    @(negedge clk);
    check("oreg popped o_valid", 32'(o_valid1), 0);
    check("oreg popped o_count", 32'(count1), 0);
    ready1 = 0;
    accepted = 0;
    for (int k = 0; k < 10; k++) begin
      valid1 = 1;
      data1  = 8'(8'h10 + k);
      if (o_ready1) accepted++;
      @(negedge clk);
    end
    valid1 = 0;
    check("oreg capacity words", 32'(accepted), 7);
    check("oreg full o_count", 32'(count1), 7);
    check("oreg full o_ready", 32'(o_ready1), 0);
    check("oreg full o_afull", 32'(afull1), 1);
    ready1 = 1;
    got = 0;
    for (int k = 0; k < 20 && got < 7; k++) begin
      if (o_valid1) begin
        check("oreg drain o_data", 32'(odata1), 32'(8'h10 + got));
        got++;
      end
      @(negedge clk);
    end
    ready1 = 0;
    check("oreg drained words", 32'(got), 7);
    check("oreg drained o_count", 32'(count1), 0);

    // Randomized traffic with alternating fill/drain bias and rare flushes.
    for (int i = 0; i < 600; i++) begin
      logic f, v, r;
      f = ($urandom_range(0, 59) == 0);
      if ((i % 120) < 60) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      step0(f, v, 8'($urandom), r);
      check_model("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_level.md
FIFO_LEVEL -- requirements
Module: fifo_level

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 6, storage entries (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter AFULL_TH, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-004 SHALL have parameter AEMPTY_TH, default 1, almost-empty threshold (0..DEPTH-1).
REQ-005 SHALL have parameter OUT_REG, default 0: 0 = show-ahead output read from storage; 1 = registered output stage.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port i_flush  input  1  synchronous clear of all contents.
REQ-009 SHALL have port i_valid  input  1  slave-side data valid.
REQ-010 SHALL have port o_ready  output  1  slave-side ready.
REQ-011 SHALL have port i_data  input  DWIDTH  slave-side data.
REQ-012 SHALL have port o_valid  output  1  master-side data valid.
REQ-013 SHALL have port i_ready  input  1  master-side ready.
REQ-014 SHALL have port o_data  output  DWIDTH  master-side data.
REQ-015 SHALL have port o_count  output  CW = clog2(DEPTH+OUT_REG+1)  registered fill level.
REQ-016 SHALL have ports o_afull and o_aempty  output  1  each, threshold flags.

Function
REQ-017 Push SHALL occur when i_valid & o_ready; pop SHALL occur when o_valid & i_ready; data SHALL be unchanged when i_valid=1 and o_ready=0.
REQ-018 Storage pointers SHALL wrap from DEPTH-1 to 0, toggling a wrap bit; full = addresses equal and wrap bits differ; empty = addresses and wrap bits equal.
REQ-019 With OUT_REG=0, o_valid = !empty and o_data = entry at read pointer; a word pushed at edge N SHALL be visible at o_data after edge N (1-cycle latency).
REQ-020 With OUT_REG=1, the output register SHALL load from storage whenever it is empty or being popped and storage is non-empty; write-to-o_valid latency SHALL be 2 cycles; total capacity SHALL be DEPTH+1.
REQ-021 o_ready SHALL be !full of storage; a push into a full FIFO SHALL NOT occur even if a pop occurs in the same cycle.
REQ-022 o_count SHALL increment on push-only, decrement on pop-only, hold on push+pop or neither; it SHALL include the output register when OUT_REG=1.
REQ-023 o_afull SHALL equal (o_count >= AFULL_TH); o_aempty SHALL equal (o_count <= AEMPTY_TH); both derived from the registered count.
REQ-024 i_flush=1 at an edge SHALL clear pointers, wrap bits, count and output-register valid; any push/pop in that cycle SHALL be discarded; flush SHALL have priority over all other activity.
REQ-025 o_data SHALL be undefined-free after reset only when o_valid=1; consumers SHALL ignore o_data while o_valid=0.
REQ-026 Order SHALL be strictly first-in-first-out with no loss or duplication across any number of wrap-arounds.

Reset
REQ-027 reset assertion SHALL immediately clear pointers, wrap bits, o_count=0, output-register valid=0; hence o_valid=0, o_ready=1, o_afull=(AFULL_TH==0 ? 1 : 0), o_aempty=1.
REQ-028 Storage array SHALL NOT be reset (distributed RAM inference); output data register MAY be left unreset.
REQ-029 reset asserted mid-transfer SHALL discard all contents; first post-reset push SHALL be the first word popped.

Structure
REQ-030 Shared package SHALL hold the clog2 function and the count/pointer width derivations.
REQ-031 One sub-module fifo_wrap_ptr SHALL implement a modulo-DEPTH pointer with wrap bit, advance enable and synchronous clear; instantiated twice (read, write).

Verification
REQ-032 DWIDTH=8, DEPTH=6, OUT_REG=0: push 0x01..0x06 with i_ready=0 -> o_ready=0 after sixth push, o_count=6, o_afull=1; drain -> 0x01..0x06 in order, o_aempty=1 at count 1.
REQ-033 Full FIFO, i_valid=1 and i_ready=1 same cycle -> pop occurs, push rejected, o_count=5; next cycle push accepted, o_count=6.
REQ-034 Continuous push+pop for 20 cycles (wraps 3x) -> o_count constant, output sequence equals input sequence.
REQ-035 OUT_REG=1: push 0xA5 at edge N with i_ready=1 -> o_valid=1 after edge N+1; capacity 7 words before o_ready=0.
REQ-036 Count=4, i_flush=1 with simultaneous push -> next cycle o_count=0, o_valid=0, pushed word absent.
REQ-037 Assert reset asynchronously between edges at count=3 -> o_valid=0, o_count=0 immediately, before next clk edge.
